multicycle_cu: RTL

MULTICYCLE_CU -- requirements
Module: multicycle_cu

---
 rtl/multicycle_cu.sv | 287 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_cu.sv
// ---------------------------------------------------------------------------
// multicycle_cu -- control unit for a multi-cycle RV32I-style datapath.
//
// Steps each instruction through FETCH -> DECODE -> EXEC -> [MEM] -> [WB].
// The datapath strobes are decoded from the state register and the
// instruction word. A few strobes also follow the handshake inputs in the
// states that sample them: ir_we, and pc_we on store completion, follow
// mem_ready, and pc_sel on a branch follows br_taken.
//
// Parameters
//   ALU_OP_W     width of alu_op (5..8); bits above the decoded field are 0
//   MEM_TIMEOUT  cycles to wait for mem_ready before trapping (0 = never)
//
// Configuration macro
//   CU_TRAP_EN   when defined, adds the TRAP state. Unknown opcodes and
//                memory timeouts then trap. When undefined, unknown opcodes
//                execute as a NOP, trap is tied low, and memory waits have
//                no limit.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   instr           instruction register contents (stable from DECODE on)
//   mem_ready       memory completes the current request this cycle
//   br_taken        branch-compare result, valid in EXEC
//   state           FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 TRAP=5
//   mem_req/mem_we  memory request / write enable
//   addr_sel        memory address source (0=PC, 1=ALU)
//   ir_we, pc_we    instruction register / PC write strobes
//   rf_read, rf_we  register-file read / write strobes
//   a_sel, b_sel    ALU A source (1=PC), ALU B source (1=imm)
//   imm_sel         immediate decode enable
//   pc_sel          next PC: 0=PC+4, 1=ALU target, 2=trap vector
//   wb_sel          write-back source: 0=ALU, 1=memory, 2=PC+4
//   alu_op          ALU operation code
//   trap            high while in TRAP
// ---------------------------------------------------------------------------
module multicycle_cu #(
    parameter int ALU_OP_W    = 5,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [31:0]         instr,
    input  logic                mem_ready,
    input  logic                br_taken,
    output logic [2:0]          state,
    output logic                mem_req,
    output logic                mem_we,
    output logic                addr_sel,
    output logic                ir_we,
    output logic                pc_we,
    output logic                rf_read,
    output logic                rf_we,
    output logic                a_sel,
    output logic                b_sel,
    output logic                imm_sel,
    output logic [1:0]          pc_sel,
    output logic [1:0]          wb_sel,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                trap
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
`ifdef CU_TRAP_EN
    localparam logic [2:0] S_TRAP   = 3'd5;
`endif

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // Wait counter sized to hold MEM_TIMEOUT itself (it saturates there).
    localparam int              CNT_W   = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);

    logic [2:0]       state_next;
    logic [CNT_W-1:0] wait_cnt;
    logic             run;

    logic [6:0] opcode;
    logic [2:0] f3;
    logic       b30;
    logic       is_r, is_i, is_load, is_store, is_branch;
    logic       is_jal, is_jalr, is_lui, is_auipc, is_link, op_to_wb;

    assign opcode    = instr[6:0];
    assign f3        = instr[14:12];
    assign b30       = instr[30];
    assign is_r      = (opcode == OP_R);
    assign is_i      = (opcode == OP_I);
    assign is_load   = (opcode == OP_LOAD);
    assign is_store  = (opcode == OP_STORE);
    assign is_branch = (opcode == OP_BRANCH);
    assign is_jal    = (opcode == OP_JAL);
    assign is_jalr   = (opcode == OP_JALR);
    assign is_lui    = (opcode == OP_LUI);
    assign is_auipc  = (opcode == OP_AUIPC);
    assign is_link   = is_jal | is_jalr;
    assign op_to_wb  = is_r | is_i | is_link | is_lui | is_auipc;

`ifdef CU_TRAP_EN
    logic op_known;
    logic timeout;

    assign op_known = op_to_wb | is_load | is_store | is_branch;
    // Trap on the edge that would bring the counter up to MEM_TIMEOUT,
    // i.e. after MEM_TIMEOUT consecutive cycles without mem_ready.
    assign timeout  = (MEM_TIMEOUT > 0) && !mem_ready && (wait_cnt == CNT_MAX - 1'b1);

    // Register-operand and immediate fields feed the datapath, not this unit.
    logic unused_bits;
    assign unused_bits = ^{instr[31], instr[29:15], instr[11:7]};
`else
    // Operand fields belong to the datapath; without traps nothing here
    // consumes the wait counter, which is kept for observability.
    logic unused_bits;
    assign unused_bits = ^{instr[31], instr[29:15], instr[11:7], wait_cnt};
`endif

    // run is low while in reset and for the first cycle after release, so
    // every strobe stays low until the first clock edge starts FETCH.
    // NOTE: sequential state is assigned with <= so every flop samples the
    // pre-edge values of its neighbours regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run <= 1'b0;
        end else begin
            run <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Wait counter: cleared when FETCH or MEM is entered, counts cycles
    // without mem_ready while waiting in those states.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if ((state_next != state) &&
                     ((state_next == S_FETCH) || (state_next == S_MEM))) begin
            wait_cnt <= '0;
        end else if (run && ((state == S_FETCH) || (state == S_MEM)) &&
                     !mem_ready && (wait_cnt != CNT_MAX)) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // NOTE: every variable written in an always_comb gets a default first,
    // so no path through the case statement can infer a latch.
    always_comb begin
        state_next = state;
        if (run) begin
            case (state)
                S_FETCH: begin
                    if (mem_ready) begin
                        state_next = S_DECODE;
                    end
`ifdef CU_TRAP_EN
                    else if (timeout) begin
                        state_next = S_TRAP;
                    end
`endif
                end
                S_DECODE: begin
`ifdef CU_TRAP_EN
                    state_next = op_known ? S_EXEC : S_TRAP;
`else
                    state_next = S_EXEC;
`endif
                end
                S_EXEC: begin
                    if (is_load || is_store) begin
                        state_next = S_MEM;
                    end else if (op_to_wb) begin
                        state_next = S_WB;
                    end else begin
                        // Branches and (untrapped) unknown opcodes finish here.
                        state_next = S_FETCH;
                    end
                end
                S_MEM: begin
                    if (mem_ready) begin
                        state_next = is_store ? S_FETCH : S_WB;
                    end
`ifdef CU_TRAP_EN
                    else if (timeout) begin
                        state_next = S_TRAP;
                    end
`endif
                end
                S_WB:    state_next = S_FETCH;
                default: state_next = S_FETCH;  // TRAP and unused encodings
            endcase
        end
    end

    always_comb begin
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        addr_sel = 1'b0;
        ir_we    = 1'b0;
        pc_we    = 1'b0;
        rf_read  = 1'b0;
        rf_we    = 1'b0;
        a_sel    = 1'b0;
        b_sel    = 1'b0;
        imm_sel  = 1'b0;
        pc_sel   = 2'd0;
        wb_sel   = 2'd0;
        alu_op   = '0;
        trap     = 1'b0;
        if (run) begin
            case (state)
                S_FETCH: begin
                    mem_req = 1'b1;
                    ir_we   = mem_ready;
                end
                S_DECODE: begin
                    rf_read = 1'b1;
                end
                S_EXEC: begin
                    if (is_r) begin
                        alu_op[3:0] = {b30, f3};
                    end else if (is_i) begin
                        b_sel       = 1'b1;
                        imm_sel     = 1'b1;
                        // instr[30] only selects SRAI vs SRLI among immediates.
                        alu_op[3]   = b30 && (f3 == 3'b101);
                        alu_op[2:0] = f3;
                    end else if (is_load || is_store || is_lui) begin
                        b_sel = 1'b1;
                    end else if (is_auipc) begin
                        a_sel = 1'b1;
                        b_sel = 1'b1;
                    end else if (is_branch) begin
                        alu_op[ALU_OP_W-1] = 1'b1;
                        alu_op[2:0]        = f3;
                        pc_we              = 1'b1;
                        pc_sel             = br_taken ? 2'd1 : 2'd0;
                    end else if (is_jal) begin
                        a_sel = 1'b1;
                    end else if (!is_jalr) begin
                        pc_we = 1'b1;  // unknown opcode: advance PC as a NOP
                    end
                end
                S_MEM: begin
                    mem_req  = 1'b1;
                    addr_sel = 1'b1;
                    mem_we   = is_store;
                    pc_we    = is_store && mem_ready;
                end
                S_WB: begin
                    rf_we  = 1'b1;
                    pc_we  = 1'b1;
                    wb_sel = is_load ? 2'd1 : (is_link ? 2'd2 : 2'd0);
                    pc_sel = is_link ? 2'd1 : 2'd0;
                end
`ifdef CU_TRAP_EN
                S_TRAP: begin
                    trap   = 1'b1;
                    pc_sel = 2'd2;
                    pc_we  = 1'b1;
                end
`endif
                default: begin
                end
            endcase
        end
    end

endmodule
